bus_sram: RTL and testbench

Parametrised single-port word SRAM slave for the native valid/ready memory bus, with configurable base address, depth and wait states. Successor to the fixed-latency scratch memory: adds an explicit transaction state machine, programmable access latency, reset-defined outputs and optional decode-error responses. Sits on the core's data/instruction bus alongside other address-decoded slaves.

---
 rtl/bus_sram_if.sv | 19 +
 rtl/bus_sram.sv | 126 ++++++++++++
 tb/tb_bus_sram.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_sram_if.sv
// Native valid/ready memory bus between a core master and an address-decoded slave.
// The err response wire exists only when BUS_SRAM_DECERR_EN is defined.
interface bus_sram_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
`ifdef BUS_SRAM_DECERR_EN
    logic        err;

    modport master (output valid, wen, addr, wdata, input ready, rdata, err);
    modport slave  (input valid, wen, addr, wdata, output ready, rdata, err);
`else
    modport master (output valid, wen, addr, wdata, input ready, rdata);
    modport slave  (input valid, wen, addr, wdata, output ready, rdata);
`endif
endinterface

// File: rtl/bus_sram.sv
// Single-port word SRAM slave with programmable wait states and read-before-write data.
// Optional macro BUS_SRAM_DECERR_EN: answer out-of-range requests with err=1 and 32'hDEAD_BEEF.
module bus_sram #(
    parameter int unsigned WORDS       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h2040_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    bus_sram_if.slave bus
);
    localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [32:0] LO   = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI   = LO + (33'(WORDS) * 33'd4);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;
    logic [IDXW-1:0] r_idx;
    logic [3:0]      r_wen;
    logic [31:0]     r_wdata;
    logic            r_ready;
    logic [31:0]     r_rdata;
    logic [31:0]     r_mem [WORDS];

    logic [32:0]     w_addr33;
    logic            w_hit;
    logic [31:0]     w_offset;
    logic [IDXW-1:0] w_idx;
    logic            w_accept;
    logic            w_access;
    logic            w_miss;
    logic            w_unused;

    // 33-bit compare keeps the top of the window from wrapping past 2^32
    assign w_addr33 = {1'b0, bus.addr};
    assign w_hit    = (w_addr33 >= LO) && (w_addr33 < HI);
    assign w_offset = bus.addr - BASE_ADDR;
    assign w_idx    = w_offset[IDXW+1:2];
    assign w_unused = &{1'b0, w_offset[31:IDXW+2], w_offset[1:0]};

`ifdef BUS_SRAM_DECERR_EN
    logic r_miss;
    logic r_err;

    assign w_accept = bus.valid;
    assign w_miss   = r_miss;
    assign bus.err  = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_accept)
                r_miss <= !w_hit;
            r_err <= w_access ? r_miss : 1'b0;
        end
    end
`else
    // Misses are left for another slave on the shared bus to answer
    assign w_accept = bus.valid && w_hit;
    assign w_miss   = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_access    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = 4'(WAIT_STATES);
                end
            end
            S_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_idx   <= '0;
            r_wen   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= w_access;
            if (r_state == S_IDLE && w_accept) begin
                r_idx   <= w_idx;
                r_wen   <= bus.wen;
                r_wdata <= bus.wdata;
            end
            if (w_access)
                r_rdata <= w_miss ? 32'hDEAD_BEEF : r_mem[r_idx];
        end
    end

    // Storage is never reset; the write is gated by the reset-cleared FSM state
    always_ff @(posedge clk) begin
        if (w_access && !w_miss) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (r_wen[b])
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
        end
    end

    assign bus.ready = r_ready;
    assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_bus_sram.sv
// Bench for bus_sram: three instances (WAIT_STATES 0, 3, 5) against a word/byte-level memory model.
// Decode-error expectations follow BUS_SRAM_DECERR_EN.
module tb_bus_sram;
    localparam logic [31:0] BASE = 32'h2040_0000;
    localparam int NW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [3];
    logic        t_valid [3];
    logic [3:0]  t_wen   [3];
    logic [31:0] t_addr  [3];
    logic [31:0] t_wdata [3];
    logic        o_ready [3];
    logic [31:0] o_rdata [3];
`ifdef BUS_SRAM_DECERR_EN
    logic        o_err   [3];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem   [3][NW];
    logic [3:0]  m_known [3][NW];

    bus_sram_if bif0();
    bus_sram_if bif3();
    bus_sram_if bif5();

    bus_sram #(.WORDS(256), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n[0]), .bus(bif0));
    bus_sram #(.WORDS(256), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n[1]), .bus(bif3));
    bus_sram #(.WORDS(256), .BASE_ADDR(BASE), .WAIT_STATES(5)) dut5 (.clk(clk), .rst_n(rst_n[2]), .bus(bif5));

    assign bif0.valid = t_valid[0];
    assign bif0.wen   = t_wen[0];
    assign bif0.addr  = t_addr[0];
    assign bif0.wdata = t_wdata[0];
    assign o_ready[0] = bif0.ready;
    assign o_rdata[0] = bif0.rdata;
    assign bif3.valid = t_valid[1];
    assign bif3.wen   = t_wen[1];
    assign bif3.addr  = t_addr[1];
    assign bif3.wdata = t_wdata[1];
    assign o_ready[1] = bif3.ready;
    assign o_rdata[1] = bif3.rdata;
    assign bif5.valid = t_valid[2];
    assign bif5.wen   = t_wen[2];
    assign bif5.addr  = t_addr[2];
    assign bif5.wdata = t_wdata[2];
    assign o_ready[2] = bif5.ready;
    assign o_rdata[2] = bif5.rdata;
`ifdef BUS_SRAM_DECERR_EN
    assign o_err[0] = bif0.err;
    assign o_err[1] = bif3.err;
    assign o_err[2] = bif5.err;
`endif

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 5;
    endfunction

    function automatic bit is_hit(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * NW);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    function automatic void model_write(input int d, input int idx, input logic [3:0] w, input logic [31:0] wd);
        for (int b = 0; b < 4; b++) begin
            if (w[b]) m_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
        end
        m_known[d][idx] = m_known[d][idx] | w;
    endfunction

    function automatic logic [31:0] known_mask(input int d, input int idx);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{m_known[d][idx][b]}};
        return m;
    endfunction

    task automatic wait_ready(input int d, input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (o_ready[d] === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // One complete request from IDLE; returns rdata seen with ready
    task automatic run_txn(input int d, input logic [31:0] a, input logic [3:0] w,
                           input logic [31:0] wd, input string name, output logic [31:0] rd);
        int exp_lat, lat, idx;
        bit hit, expect_ack, bad;
        logic [31:0] mask, exp_rd;
        exp_lat = ws_of(d) + 2;
        hit = is_hit(a);
        idx = hit ? idx_of(a) : 0;
`ifdef BUS_SRAM_DECERR_EN
        expect_ack = 1'b1;
`else
        expect_ack = hit;
`endif
        t_valid[d] = 1'b1; t_addr[d] = a; t_wen[d] = w; t_wdata[d] = wd;
        rd = 'x;
        if (expect_ack) begin
            wait_ready(d, exp_lat + 4, lat);
            rd = o_rdata[d];
            t_valid[d] = 1'b0;
            n_tests++;
            if (lat != exp_lat) begin
                n_fail++;
                $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
            end
            if (hit) begin
                mask = known_mask(d, idx);
                exp_rd = m_mem[d][idx];
                n_tests++;
                if ((rd & mask) !== (exp_rd & mask)) begin
                    n_fail++;
                    $display("FAIL %s rdata: got %08h, expected %08h (mask %08h)", name, rd, exp_rd, mask);
                end
                model_write(d, idx, w, wd);
`ifdef BUS_SRAM_DECERR_EN
                n_tests++;
                if (o_err[d] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s err on hit: got %b, expected 0", name, o_err[d]);
                end
            end else begin
                n_tests++;
                if (o_err[d] !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL %s decerr: got err=%b rdata=%08h, expected err=1 rdata=deadbeef", name, o_err[d], rd);
                end
`endif
            end
            @(posedge clk); #1;
            n_tests++;
            if (o_ready[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s ready pulse width: got ready=%b after ACK, expected 0", name, o_ready[d]);
            end
        end else begin
            bad = 1'b0;
            repeat (exp_lat + 4) begin
                @(posedge clk); #1;
                if (o_ready[d] !== 1'b0) bad = 1'b1;
            end
            t_valid[d] = 1'b0;
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s miss ignored: got a ready pulse, expected none", name);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        bit bad;
        #3;
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if (o_ready[d] !== 1'b0 || o_rdata[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset dut%0d: got ready=%b rdata=%08h, expected 0/00000000", d, o_ready[d], o_rdata[d]);
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) if (o_ready[d] !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL idle after reset: got a ready pulse, expected none");
        end
    endtask

    task automatic test_ws0;
        logic [31:0] rd;
        run_txn(0, 32'h2040_0010, 4'hF, 32'h1234_5678, "ws0_write", rd);
        run_txn(0, 32'h2040_0010, 4'h0, 32'h0, "ws0_read", rd);
        n_tests++;
        if (rd !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL ws0 readback: got %08h, expected 12345678", rd);
        end
        #2 rst_n[0] = 1'b0;
        #1;
        n_tests++;
        if (o_rdata[0] !== 32'h0 || o_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL async reset: got rdata=%08h ready=%b, expected 0", o_rdata[0], o_ready[0]);
        end
        @(negedge clk) rst_n[0] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_byte_enables;
        logic [31:0] rd;
        run_txn(0, 32'h2040_0024, 4'hF, 32'hAABB_CCDD, "be_init", rd);
        run_txn(0, 32'h2040_0024, 4'b0101, 32'h1122_3344, "be_write", rd);
        n_tests++;
        if (rd !== 32'hAABB_CCDD) begin
            n_fail++;
            $display("FAIL be pre-write data: got %08h, expected aabbccdd", rd);
        end
        run_txn(0, 32'h2040_0024, 4'h0, 32'hFFFF_FFFF, "be_read", rd);
        n_tests++;
        if (rd !== 32'hAA22_CC44) begin
            n_fail++;
            $display("FAIL be merged data: got %08h, expected aa22cc44", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r1, r2, rd;
        int lat, idx;
        bit bad;
        r1 = $urandom; r2 = $urandom;
        idx = idx_of(32'h2040_0040);
        t_valid[1] = 1'b1; t_addr[1] = 32'h2040_0040; t_wen[1] = 4'hF; t_wdata[1] = r1;
        wait_ready(1, 12, lat);
        n_tests++;
        if (lat != 5) begin
            n_fail++;
            $display("FAIL b2b first latency: got %0d, expected 5", lat);
        end
        t_wen[1] = 4'h0; t_wdata[1] = 32'h0;
        wait_ready(1, 12, lat);
        n_tests++;
        if (lat != 6 || o_rdata[1] !== r1) begin
            n_fail++;
            $display("FAIL b2b read: got spacing %0d rdata %08h, expected 6 and %08h", lat, o_rdata[1], r1);
        end
        t_wen[1] = 4'hF; t_wdata[1] = r2;
        wait_ready(1, 12, lat);
        n_tests++;
        if (lat != 6 || o_rdata[1] !== r1) begin
            n_fail++;
            $display("FAIL b2b write2: got spacing %0d rdata %08h, expected 6 and %08h", lat, o_rdata[1], r1);
        end
        t_valid[1] = 1'b0;
        model_write(1, idx, 4'hF, r2);
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (o_ready[1] !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL b2b duplicate: got an extra ready pulse, expected none");
        end
        run_txn(1, 32'h2040_0040, 4'h0, 32'h0, "b2b_final_read", rd);
    endtask

    task automatic test_range_edges;
        logic [31:0] rd, v;
        v = $urandom;
        run_txn(0, 32'h2040_03FC, 4'hF, v, "edge_top_write", rd);
        run_txn(0, 32'h2040_03FC, 4'h0, 32'h0, "edge_top_read", rd);
        n_tests++;
        if (rd !== v) begin
            n_fail++;
            $display("FAIL edge top word: got %08h, expected %08h", rd, v);
        end
        run_txn(0, 32'h2040_0400, 4'hF, 32'h5555_5555, "edge_above", rd);
        run_txn(0, 32'h203F_FFFC, 4'hF, 32'h6666_6666, "edge_below", rd);
        run_txn(1, 32'hFFFF_FFFC, 4'h0, 32'h0, "edge_wrap", rd);
        run_txn(0, 32'h2040_0000, 4'h0, 32'h0, "edge_bottom_read", rd);
    endtask

    task automatic test_reset_during_wait;
        logic [31:0] rd;
        bit bad;
        run_txn(2, 32'h2040_0020, 4'hF, 32'hCAFE_F00D, "abort_init", rd);
        t_valid[2] = 1'b1; t_addr[2] = 32'h2040_0020; t_wen[2] = 4'hF; t_wdata[2] = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[2] = 1'b0;
        t_valid[2] = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (o_ready[2] !== 1'b0) bad = 1'b1;
        end
        @(negedge clk) rst_n[2] = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (o_ready[2] !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL abort ready: got a ready pulse for aborted request, expected none");
        end
        run_txn(2, 32'h2040_0020, 4'h0, 32'h0, "abort_readback", rd);
        n_tests++;
        if (rd !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL abort readback: got %08h, expected cafef00d", rd);
        end
    endtask

    task automatic test_random;
        logic [31:0] a, rd;
        logic [3:0] w;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 6) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       a = BASE + 32'h400 + 4 * $urandom_range(0, 15);
                        1:       a = BASE - 4 * $urandom_range(1, 15);
                        default: a = $urandom & 32'h0FFF_FFFF;
                    endcase
                end else begin
                    a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
                end
                w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
                run_txn(d, a, w, $urandom, "random", rd);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b1; t_valid[d] = 1'b0; t_wen[d] = '0; t_addr[d] = '0; t_wdata[d] = '0;
            for (int i = 0; i < NW; i++) begin
                m_mem[d][i] = '0;
                m_known[d][i] = '0;
            end
        end
        test_reset;
        @(posedge clk); #1;
        test_ws0;
        test_byte_enables;
        test_back_to_back;
        test_range_edges;
        test_reset_during_wait;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
